// File: rtl/pipeline_pkg.sv
`default_nettype none
// pipeline_pkg: types and constants shared by the pipeline front end.
// Revision: 1.0
package pipeline_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: instruction-fetch front end; owns the PC, one outstanding imem fetch.
// Revision: 1.0
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(pipeline_pkg::NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o
);

  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  deliver;
  logic                  unused_redirect_low;

  // Targets are word aligned; the low bits of the redirect PC are dropped.
  assign redirect_target     = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc_i[1:0];
  assign pc_next             = pc_q + STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc_q  <= RESET_PC;
      buf_q <= NOP_INSTR;
    end else if (redirect_i) begin
      pc_q <= redirect_target;
      // A fetch already granted must still drain its rvalid before re-issuing.
      case (state)
        REQ:     state <= imem_gnt_i    ? DROP : REQ;
        WAIT:    state <= imem_rvalid_i ? REQ  : DROP;
        HOLD:    state <= REQ;
        DROP:    state <= imem_rvalid_i ? REQ  : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (imem_gnt_i) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (stall_i) begin
              buf_q <= imem_rdata_i;
              state <= HOLD;
            end else begin
              pc_q  <= pc_next;
              state <= REQ;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            pc_q  <= pc_next;
            state <= REQ;
          end
        end
        DROP: begin
          if (imem_rvalid_i) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  assign deliver = !rst && !redirect_i &&
                   (((state == WAIT) && imem_rvalid_i) || (state == HOLD));

  assign imem_req_o  = !rst && (state == REQ);
  assign imem_addr_o = pc_q;
  assign valid_o     = deliver;
  assign instr_o     = !deliver        ? NOP_INSTR :
                       (state == HOLD) ? buf_q     : imem_rdata_i;
  assign pc_o        = rst ? '0 : pc_q;
  assign pc_plus4_o  = rst ? '0 : pc_next;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: table vectors plus scoreboard against a simple latency-configurable imem model.
// Revision: 1.0
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[7];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        auto_gnt;
  int          lat;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] req_addr;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = word(pc);
    sb.push_back(e);
  endtask

  // Drive the memory side for this cycle, then sample and score the outputs.
  task automatic drive_mem();
    #1;
    imem_gnt_i    = auto_gnt && imem_req_o;
    imem_rvalid_i = (pend_cnt == 1);
    imem_rdata_i  = (pend_cnt == 1) ? word(pend_addr) : 32'hDEAD_BEEF;
    req_addr      = imem_addr_o;
    #1;
    if (!rst) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got pc %h, expected no instruction", pc_o);
        end else begin
          chk("sb_pc", pc_o, sb[0].pc);
          chk("sb_instr", instr_o, sb[0].instr);
          chk("sb_pc4", pc_plus4_o, sb[0].pc + 32'd4);
          if (!stall_i) void'(sb.pop_front());
        end
      end else begin
        chk("bubble_instr", instr_o, NOP);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (imem_gnt_i) begin
      pend_cnt  = lat;
      pend_addr = req_addr;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
    end
    #1;
  endtask

  task automatic tick();
    drive_mem();
    advance();
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    n_checks++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit seen;

    tbl[0] = '{rst: 1'b1, req: 1'b0, addr: 32'h0, valid: 1'b0, pc: 32'h0};
    tbl[1] = '{rst: 1'b0, req: 1'b1, addr: 32'h0, valid: 1'b0, pc: 32'h0};
    tbl[2] = '{rst: 1'b0, req: 1'b0, addr: 32'h0, valid: 1'b1, pc: 32'h0};
    tbl[3] = '{rst: 1'b0, req: 1'b1, addr: 32'h4, valid: 1'b0, pc: 32'h0};
    tbl[4] = '{rst: 1'b0, req: 1'b0, addr: 32'h0, valid: 1'b1, pc: 32'h4};
    tbl[5] = '{rst: 1'b0, req: 1'b1, addr: 32'h8, valid: 1'b0, pc: 32'h0};
    tbl[6] = '{rst: 1'b0, req: 1'b0, addr: 32'h0, valid: 1'b1, pc: 32'h8};

    rst           = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    auto_gnt      = 1'b1;
    lat           = 1;
    pend_cnt      = 0;
    pend_addr     = 32'h0;
    req_addr      = 32'h0;
    @(posedge clk);
    #1;

    // Reset cycle followed by back-to-back fetches from a zero-wait memory.
    push(32'h0);
    push(32'h4);
    push(32'h8);
    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst;
      drive_mem();
      chk($sformatf("v%0d_req", i), {31'b0, imem_req_o}, {31'b0, tbl[i].req});
      chk($sformatf("v%0d_valid", i), {31'b0, valid_o}, {31'b0, tbl[i].valid});
      if (tbl[i].req) chk($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].addr);
      if (tbl[i].valid || tbl[i].rst) chk($sformatf("v%0d_pc", i), pc_o, tbl[i].pc);
      if (tbl[i].rst) begin
        chk("rst_pc4", pc_plus4_o, 32'h0);
        chk("rst_instr", instr_o, NOP);
      end
      advance();
    end

    // Stall for three cycles on the 0x10 response.
    push(32'hC);
    push(32'h10);
    tick();
    tick();
    drive_mem();
    chk("stall_addr", imem_addr_o, 32'h10);
    advance();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_mem();
      chk("stall_valid", {31'b0, valid_o}, 32'h1);
      chk("stall_pc", pc_o, 32'h10);
      chk("stall_instr", instr_o, word(32'h10));
      chk("stall_noreq", {31'b0, imem_req_o}, 32'h0);
      advance();
    end
    stall_i = 1'b0;
    drive_mem();
    chk("release_valid", {31'b0, valid_o}, 32'h1);
    chk("release_pc", pc_o, 32'h10);
    chk("release_noreq", {31'b0, imem_req_o}, 32'h0);
    advance();
    drive_mem();
    chk("after_stall_addr", imem_addr_o, 32'h14);
    chk("after_stall_req", {31'b0, imem_req_o}, 32'h1);
    lat = 3;
    advance();

    // Redirect while waiting; the late word for 0x14 must be discarded.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    drive_mem();
    chk("redir_wait_valid", {31'b0, valid_o}, 32'h0);
    advance();
    redirect_i = 1'b0;
    drive_mem();
    chk("drop_noreq", {31'b0, imem_req_o}, 32'h0);
    advance();
    drive_mem();
    chk("drop_late_valid", {31'b0, valid_o}, 32'h0);
    chk("drop_late_noreq", {31'b0, imem_req_o}, 32'h0);
    advance();
    lat = 1;
    push(32'h200);
    drive_mem();
    chk("redir_addr", imem_addr_o, 32'h200);
    chk("redir_req", {31'b0, imem_req_o}, 32'h1);
    advance();
    tick();

    // Unaligned redirect in REQ with no grant; address held until granted.
    auto_gnt      = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h103;
    drive_mem();
    chk("redir_req_valid", {31'b0, valid_o}, 32'h0);
    advance();
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_mem();
      chk("aligned_addr", imem_addr_o, 32'h100);
      chk("aligned_req", {31'b0, imem_req_o}, 32'h1);
      advance();
    end
    auto_gnt = 1'b1;
    push(32'h100);
    drain(10);

    // Redirect while the request is granted, to the last word of the address space.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    drive_mem();
    advance();
    redirect_i = 1'b0;
    push(32'hFFFF_FFFC);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      drive_mem();
      if (valid_o) begin
        chk("wrap_pc4", pc_plus4_o, 32'h0);
        seen = 1'b1;
      end
      advance();
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL wrap_timeout: valid_o never seen, expected one instruction");
      sb.delete();
    end

    // Reset while waiting; the stray response after reset must be ignored.
    lat = 3;
    drive_mem();
    advance();
    rst = 1'b1;
    drive_mem();
    chk("midrst_req", {31'b0, imem_req_o}, 32'h0);
    chk("midrst_valid", {31'b0, valid_o}, 32'h0);
    chk("midrst_pc", pc_o, 32'h0);
    chk("midrst_instr", instr_o, NOP);
    advance();
    rst      = 1'b0;
    auto_gnt = 1'b0;
    drive_mem();
    chk("postrst_addr", imem_addr_o, 32'h0);
    advance();
    drive_mem();
    chk("stray_valid", {31'b0, valid_o}, 32'h0);
    chk("stray_req", {31'b0, imem_req_o}, 32'h1);
    advance();
    auto_gnt = 1'b1;
    lat      = 1;
    push(32'h0);
    drain(10);

    // Random stalls and memory latency over a straight-line run.
    for (int a = 4; a <= 32'h20; a += 4) push(32'(a));
    for (int n = 0; n < 300 && sb.size() > 0; n++) begin
      stall_i = ($urandom_range(0, 2) == 0);
      lat     = int'($urandom_range(1, 3));
      tick();
    end
    stall_i = 1'b0;
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
